// File: rtl/sd_pkg.sv
// sd_pkg: shared states and framing constants for the SD command-line controller.
package sd_pkg;
  typedef enum logic [2:0] {INIT_CLK, IDLE, TX, RX_WAIT, RX, GAP} sd_cmd_state_t;
  localparam int SD_CMD_LEN = 48;
  localparam int SD_NRC = 8;
  localparam logic [6:0] SD_CRC7_POLY = 7'h09;
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1), MSB first, synchronous clear.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       res_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) crc <= '0;
    else if (clr) crc <= '0;
    else if (en) crc <= {crc[5:0], 1'b0} ^ ({7{din ^ crc[6]}} & SD_CRC7_POLY);
endmodule

// File: rtl/sd_cmd_ctrl.sv
// sd_cmd_ctrl: SD CMD-line sequencer; response CRC check enabled by SD_CMD_RESP_CRC_EN.
module sd_cmd_ctrl
  import sd_pkg::*;
#(
  parameter int NCR_MAX   = 64,
  parameter int INIT_CLKS = 80
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        sd_clk_rise,
  input  logic        sd_clk_fall,
  output logic        speed,
  input  logic        speed_req,
  input  logic        start,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] arg,
  input  logic        resp_en,
  input  logic        resp_nocrc,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        crc_err,
  output logic [37:0] resp,
  output logic        cmd_out,
  output logic        cmd_oe,
  input  logic        cmd_in
);
  localparam logic [6:0] HDR = 7'(SD_CMD_LEN - 8);
  localparam logic [6:0] LAST = 7'(SD_CMD_LEN - 1);
  sd_cmd_state_t state, state_n;
  logic [6:0]  cnt;
  logic [39:0] frame;
  logic [6:0]  crc_tx;
  logic        resp_en_q, accept, tx_fall, tx_crc_en, tx_bit, step, rx_rise;
  assign accept    = state == IDLE && start;
  assign tx_fall   = state == TX && sd_clk_fall;
  assign tx_crc_en = tx_fall && cnt < HDR;
  assign rx_rise   = state == RX && sd_clk_rise;
  assign step      = state == TX ? sd_clk_fall : state != IDLE && sd_clk_rise;
  // header bits shift out of frame[39]; CRC bits are indexed once the header is done
  assign tx_bit = cnt < HDR ? frame[39] : cnt < LAST ? crc_tx[3'd6 - 3'(cnt - HDR)] : 1'b1;
  sd_crc7 u_crc_tx (.clk(clk), .res_n(res_n), .clr(accept), .en(tx_crc_en), .din(frame[39]), .crc(crc_tx));
  always_comb begin
    state_n = state;
    case (state)
      INIT_CLK: state_n = sd_clk_rise && cnt == 7'(INIT_CLKS - 1) ? IDLE : INIT_CLK;
      IDLE:     state_n = start ? TX : IDLE;
      TX:       state_n = sd_clk_fall && cnt == 7'(SD_CMD_LEN) ? (resp_en_q ? RX_WAIT : GAP) : TX;
      RX_WAIT:  state_n = !sd_clk_rise ? RX_WAIT : !cmd_in ? RX : cnt == 7'(NCR_MAX - 1) ? GAP : RX_WAIT;
      RX:       state_n = sd_clk_rise && cnt == LAST - 7'd1 ? GAP : RX;
      GAP:      state_n = sd_clk_rise && cnt == 7'(SD_NRC - 1) ? IDLE : GAP;
      default:  state_n = INIT_CLK;
    endcase
  end
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) state <= INIT_CLK;
    else state <= state_n;
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      cnt       <= '0;
      frame     <= '0;
      resp_en_q <= 1'b0;
      speed     <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      timeout   <= 1'b0;
      resp      <= '0;
      cmd_out   <= 1'b1;
      cmd_oe    <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= state_n != state ? '0 : step ? cnt + 7'd1 : cnt;
      if (state == IDLE) speed <= speed_req;
      if (accept) begin
        frame     <= {2'b01, cmd_idx, arg};
        resp_en_q <= resp_en;
        busy      <= 1'b1;
        timeout   <= 1'b0;
      end
      if (tx_crc_en) frame <= frame << 1;
      if (tx_fall) begin
        cmd_oe  <= cnt != 7'(SD_CMD_LEN);
        cmd_out <= tx_bit;
      end
      if (state == INIT_CLK && state_n == IDLE) busy <= 1'b0;
      if (state == RX_WAIT && state_n == GAP) timeout <= 1'b1;
      // RX count 0 is the transmission bit; counts 1..38 carry bits 45..8
      if (rx_rise && cnt != 7'd0 && cnt < HDR - 7'd1) resp <= {resp[36:0], cmd_in};
      if (state == GAP && state_n == IDLE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
`ifdef SD_CMD_RESP_CRC_EN
  logic [6:0] crc_rx, crc_rcv;
  logic       nocrc_q, rx_crc_en;
  assign rx_crc_en = sd_clk_rise && ((state == RX_WAIT && !cmd_in) || (state == RX && cnt < HDR - 7'd1));
  sd_crc7 u_crc_rx (.clk(clk), .res_n(res_n), .clr(accept), .en(rx_crc_en), .din(cmd_in), .crc(crc_rx));
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      crc_rcv <= '0;
      nocrc_q <= 1'b0;
      crc_err <= 1'b0;
    end else begin
      if (accept) begin
        nocrc_q <= resp_nocrc;
        crc_err <= 1'b0;
      end
      if (rx_rise && cnt >= HDR - 7'd1 && cnt < LAST - 7'd1) crc_rcv <= {crc_rcv[5:0], cmd_in};
      if (state == RX && state_n == GAP) crc_err <= !nocrc_q && crc_rcv != crc_rx;
    end
`else
  logic unused_nocrc;
  assign unused_nocrc = resp_nocrc;
  assign crc_err = 1'b0;
`endif
endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// tb_sd_cmd_ctrl: directed and randomized checks of sd_cmd_ctrl against a card/host model.
module tb_sd_cmd_ctrl;
  logic        clk = 0, res_n = 0, sd_clk_rise = 0, sd_clk_fall = 0;
  logic        speed, speed_req = 0, start = 0, resp_en = 0, resp_nocrc = 0;
  logic [5:0]  cmd_idx = '0;
  logic [31:0] arg = '0;
  logic        busy, done, timeout, crc_err, cmd_out, cmd_oe, cmd_in = 1;
  logic [37:0] resp;
  localparam bit CRC_EN =
`ifdef SD_CMD_RESP_CRC_EN
    1'b1;
`else
    1'b0;
`endif
  sd_cmd_ctrl dut (
    .clk(clk), .res_n(res_n), .sd_clk_rise(sd_clk_rise), .sd_clk_fall(sd_clk_fall),
    .speed(speed), .speed_req(speed_req), .start(start), .cmd_idx(cmd_idx), .arg(arg),
    .resp_en(resp_en), .resp_nocrc(resp_nocrc), .busy(busy), .done(done), .timeout(timeout),
    .crc_err(crc_err), .resp(resp), .cmd_out(cmd_out), .cmd_oe(cmd_oe), .cmd_in(cmd_in)
  );
  always #10 clk = ~clk;
  int n_chk = 0, n_fail = 0, ph = 0;
  logic last_rise = 0, last_fall = 0;
  logic [37:0] exp_resp = '0;
  logic [47:0] got_frame;
  int got_bits, rises;
  logic got_done, got_to, got_ce, got_busy, spd_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC7 as the remainder of (data * x^7) divided by x^7+x^3+1
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic dir, input logic [5:0] idx, input logic [31:0] a);
    logic [39:0] h;
    h = {1'b0, dir, idx, a};
    return {h, crc7(h), 1'b1};
  endfunction

  // SD clock period = 4 clk: rise strobe at phase 0, fall strobe at phase 2
  task automatic tick();
    @(posedge clk);
    #1;
    last_rise = sd_clk_rise;
    last_fall = sd_clk_fall;
    ph = (ph + 1) % 4;
    sd_clk_rise = ph == 0;
    sd_clk_fall = ph == 2;
  endtask

  task automatic preamble(output int n, output logic oe_bad, input logic try_start);
    n = 0;
    oe_bad = 0;
    for (int k = 0; k < 2000; k++) begin
      start = try_start && (k == 5 || k == 150);
      cmd_idx = 6'h3f;
      tick();
      if (last_rise) n++;
      if (cmd_oe) oe_bad = 1;
      if (!busy) break;
    end
    start = 0;
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] a, input logic ren, nocrc, reply,
                         input logic [47:0] rf, input int dly, input logic spd_mid);
    int di = 0, fa = 0;
    logic oe_seen = 0, tx_over = 0;
    got_frame = '0; got_bits = 0; rises = 0; got_done = 0; spd_bad = 0;
    got_to = 'x; got_ce = 'x; got_busy = 'x;
    cmd_idx = idx; arg = a; resp_en = ren; resp_nocrc = nocrc; start = 1;
    tick();
    start = 0; cmd_idx = ~idx; arg = ~a; resp_en = ~ren; resp_nocrc = ~nocrc;
    chk("busy_on_start", busy, 1);
    for (int k = 0; k < 4000 && !got_done; k++) begin
      start = 0;
      tick();
      if (oe_seen && last_rise) rises++;
      if (cmd_oe) oe_seen = 1;
      if (last_rise && cmd_oe && got_bits < 48) begin
        got_frame = {got_frame[46:0], cmd_out};
        got_bits++;
        if (got_bits == 10) start = 1;
        if (spd_mid && got_bits == 5) speed_req = 1;
      end
      if (got_bits == 48 && !cmd_oe) tx_over = 1;
      if (tx_over && reply && last_fall) begin
        if (di < 48 && fa >= dly) begin
          cmd_in = rf[47 - di];
          di++;
        end else if (di == 48) cmd_in = 1;
        fa++;
      end
      if (spd_mid && busy && speed !== 1'b0) spd_bad = 1;
      if (done) begin
        got_done = 1; got_to = timeout; got_ce = crc_err; got_busy = busy;
      end
    end
    start = 0;
    cmd_in = 1;
  endtask

  task automatic verify(input string t, input logic [47:0] ef, input int er, input logic eto, ece);
    chk({t, "_frame"}, got_frame, ef);
    chk({t, "_rises"}, rises, er);
    chk({t, "_done"}, got_done, 1);
    chk({t, "_timeout"}, got_to, eto);
    chk({t, "_crc_err"}, got_ce, ece);
    chk({t, "_busy"}, got_busy, 0);
    chk({t, "_resp"}, resp, exp_resp);
    tick();
    chk({t, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n, dly;
    logic oe_bad, ren, nocrc, flip;
    logic [5:0] idx;
    logic [31:0] a;
    logic [47:0] rf;
    repeat (3) tick();
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_crc_err", crc_err, 0);
    chk("rst_resp", resp, 0);
    chk("rst_cmd_out", cmd_out, 1);
    chk("rst_cmd_oe", cmd_oe, 0);
    chk("rst_speed", speed, 0);
    res_n = 1;
    preamble(n, oe_bad, 1);
    chk("init_rises", n, 80);
    chk("init_oe", oe_bad, 0);
    repeat (4) tick();
    chk("init_start_ignored", busy, 0);

    run_cmd(6'd0, 32'h0, 0, 0, 0, '0, 0, 0);
    verify("cmd0", 48'h400000000095, 56, 0, 0);

    rf = 48'h08000001AA13;
    run_cmd(6'd8, 32'h1AA, 1, 0, 1, rf, 3, 0);
    exp_resp = rf[45:8];
    verify("cmd8", 48'h48000001AA87, 107, 0, 0);
    chk("cmd8_resp_const", resp, 38'h08000001AA);

    run_cmd(6'd8, 32'h1AA, 1, 0, 1, rf ^ 48'h2, 5, 0);
    verify("cmd8_badcrc", 48'h48000001AA87, 109, 0, CRC_EN);

    run_cmd(6'd8, 32'h1AA, 1, 1, 1, rf ^ 48'h2, 2, 0);
    verify("cmd8_nocrc", 48'h48000001AA87, 106, 0, 0);

    a = $urandom;
    run_cmd(6'd17, a, 1, 0, 0, '0, 0, 0);
    verify("tmo", mk_frame(1, 6'd17, a), 120, 1, 0);

    run_cmd(6'd0, 32'h0, 0, 0, 0, '0, 0, 1);
    chk("spd_mid_cmd", spd_bad, 0);
    chk("spd_at_done", speed, 0);
    verify("spd", 48'h400000000095, 56, 0, 0);
    chk("spd_idle", speed, 1);
    speed_req = 0;
    tick();
    chk("spd_back", speed, 0);

    for (int r = 0; r < 6; r++) begin
      idx = 6'($urandom); a = $urandom;
      ren = 1'($urandom_range(0, 1)); nocrc = 1'($urandom_range(0, 1)); flip = 1'($urandom_range(0, 1));
      dly = $urandom_range(1, 20);
      rf = mk_frame(0, 6'($urandom), $urandom);
      if (flip) rf = rf ^ (48'h1 << $urandom_range(1, 7));
      run_cmd(idx, a, ren, nocrc, ren, rf, dly, 0);
      if (ren) exp_resp = rf[45:8];
      verify($sformatf("rnd%0d", r), mk_frame(1, idx, a), ren ? 104 + dly : 56, 0, CRC_EN && ren && flip && !nocrc);
    end

    cmd_idx = 6'd2; arg = 32'h0; resp_en = 1; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 200 && !cmd_oe; k++) tick();
    repeat (20) tick();
    chk("mid_tx_oe", cmd_oe, 1);
    res_n = 0;
    #1;
    exp_resp = '0;
    chk("arst_oe", cmd_oe, 0);
    chk("arst_cmd_out", cmd_out, 1);
    chk("arst_busy", busy, 1);
    chk("arst_resp", resp, exp_resp);
    repeat (2) tick();
    res_n = 1;
    preamble(n, oe_bad, 0);
    chk("reinit_rises", n, 80);
    chk("reinit_oe", oe_bad, 0);

    run_cmd(6'd0, 32'h0, 0, 0, 0, '0, 0, 0);
    verify("post_rst", 48'h400000000095, 56, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
